// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and the
// MEM stage; generates pipeline stalls and breaks hung transactions with a watchdog.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        im_req,
    input  logic [31:0] im_addr,
    output logic [31:0] im_rdata,
    output logic        IM_STALL,
    input  logic        dm_read,
    input  logic [3:0]  dm_web,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        DM_STALL,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_web,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic             OWN_IM   = 1'b0;
    localparam logic             OWN_DM   = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic             owner;
    logic             last_owner;
    logic [CNT_W-1:0] wd_cnt;

    logic        im_pend;
    logic        dm_pend;
    logic        grant_dm;
    logic        rsp_done;
    logic        wd_fire;
    logic        cap_en;
    logic [31:0] cap_data;

    always_comb begin
        im_pend  = im_req;
        dm_pend  = dm_read | (dm_web != 4'hf);
        // DM wins a tie unless it was served last, which keeps fetch from starving.
        grant_dm = dm_pend & (~im_pend | (last_owner == OWN_IM));
        rsp_done = (state == WAIT) & mem_rvalid;
        wd_fire  = ((state == REQ) | (state == WAIT)) & (wd_cnt == CNT_LAST) & ~rsp_done;
        cap_en   = rsp_done | wd_fire;
        cap_data = rsp_done ? mem_rdata : 32'h0;
        IM_STALL = im_pend & ~((state == DONE) & (owner == OWN_IM));
        DM_STALL = dm_pend & ~((state == DONE) & (owner == OWN_DM));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            owner       <= OWN_IM;
            last_owner  <= OWN_IM;
            wd_cnt      <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= 32'h0;
            mem_web     <= 4'hf;
            mem_wdata   <= 32'h0;
            im_rdata    <= 32'h0;
            dm_rdata    <= 32'h0;
            timeout_err <= 1'b0;
        end else begin
            // A DM write leaves dm_rdata alone; the latched web tells reads from writes.
            if (cap_en) begin
                if (owner == OWN_IM)
                    im_rdata <= cap_data;
                else if (mem_web == 4'hf)
                    dm_rdata <= cap_data;
            end
            if (wd_fire)
                timeout_err <= 1'b1;

            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (im_pend | dm_pend) begin
                        owner   <= grant_dm;
                        mem_req <= 1'b1;
                        state   <= REQ;
                        if (grant_dm) begin
                            mem_addr  <= dm_addr;
                            mem_web   <= dm_web;
                            mem_wdata <= dm_wdata;
                        end else begin
                            mem_addr  <= im_addr;
                            mem_web   <= 4'hf;
                            mem_wdata <= 32'h0;
                        end
                    end
                end
                REQ: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (wd_fire) begin
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (rsp_done | wd_fire)
                        state <= DONE;
                end
                DONE: begin
                    wd_cnt     <= '0;
                    last_owner <= owner;
                    mem_web    <= 4'hf;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
